// File: rtl/countdown_timer_pkg.sv
// Shared constants for countdown_timer: register offsets, CTRL bit layout,
// mode codes and FSM state encoding.
package countdown_timer_pkg;

  // Register offsets, decoded from Addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Mode codes; 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT    = 2'd0;
  localparam logic [1:0] MODE_AUTORELOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Field order matches the CTRL bit layout so the struct packs straight into bits [3:0]
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Register bus between the address-decoding bridge and one countdown_timer instance.
interface countdown_timer_if;
  // WE acts as the valid strobe; the timer is always ready, so every cycle with
  // WE high commits the write to the register selected by Addr[3:2] at that edge.
  // Dout is combinational on Addr; IRQ is registered.
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/countdown_timer.sv
// Memory-mapped countdown timer with maskable interrupt.
// Define TIMER_AUTORELOAD_EN to enable Mode 1 (auto-reload); otherwise one-shot only.
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus,
  output timer_state_e     dbg_state
);

  timer_state_e state, state_d;
  ctrl_t        ctrl, ctrl_d, ctrl_wdata;
  logic [31:0]  preset, count, count_d;
  logic         flag, flag_d;
  logic         irq_q;
  logic         auto_reload;
  logic         int_entry;
  logic [1:0]   reg_sel;
  logic         ctrl_wr, preset_wr;
  logic         addr_unused;

  assign reg_sel     = bus.Addr[3:2];
  assign ctrl_wr     = bus.WE && (reg_sel == REG_CTRL);
  assign preset_wr   = bus.WE && (reg_sel == REG_PRESET);
  assign addr_unused = ^{bus.Addr[29:4], bus.Addr[1:0]};

  always_comb begin
    ctrl_wdata.en = bus.Din[CTRL_EN_BIT];
    ctrl_wdata.im = bus.Din[CTRL_IM_BIT];
`ifdef TIMER_AUTORELOAD_EN
    ctrl_wdata.mode = bus.Din[CTRL_MODE_MSB:CTRL_MODE_LSB];
`else
    ctrl_wdata.mode = MODE_ONESHOT;
`endif
  end

`ifdef TIMER_AUTORELOAD_EN
  assign auto_reload = (ctrl.mode == MODE_AUTORELOAD);
`else
  assign auto_reload = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    count_d   = count;
    ctrl_d    = ctrl;
    flag_d    = flag;
    int_entry = 1'b0;
    case (state)
      ST_IDLE: if (ctrl.en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (count > 32'd1) begin
          count_d = count - 32'd1;
        end else begin
          count_d   = '0;
          state_d   = ST_INT;
          int_entry = 1'b1;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_reload) flag_d = 1'b0;
        else             ctrl_d.en = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Software CTRL writes win over the hardware Enable clear and drop the flag
    if (ctrl_wr) begin
      ctrl_d = ctrl_wdata;
      flag_d = 1'b0;
    end
    if (int_entry) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state <= state_d;
      ctrl  <= ctrl_d;
      count <= count_d;
      flag  <= flag_d;
      irq_q <= flag && ctrl.im;
      if (preset_wr) preset <= bus.Din;
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (reg_sel)
      REG_CTRL:   bus.Dout = ctrl_word(ctrl);
      REG_PRESET: bus.Dout = preset;
      REG_COUNT:  bus.Dout = count;
      REG_RSVD:   bus.Dout = '0;
      default:    bus.Dout = '0;
    endcase
  end

  assign bus.IRQ   = irq_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random register
// traffic, compared every cycle against a behavioural timer model.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  timer_state_e dbg_state;

  countdown_timer_if bus ();

  countdown_timer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;

  bit        model_live = 1'b0;
  bit        m_en, m_im, m_flag, m_irq;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;
  int        m_phase;

  bit        ev_wr_ctrl, ev_wr_preset, ev_expire, ev_reload;
  bit        irq_next;
  int        next_phase;

  function automatic bit [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic timer_state_e phase_enum(input int p);
    case (p)
      P_LOAD:  return ST_LOAD;
      P_CNT:   return ST_CNT;
      P_INT:   return ST_INT;
      default: return ST_IDLE;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      model_live = 1'b1;
      {m_en, m_im, m_flag, m_irq, m_mode} = '0;
      m_preset = 0; m_count = 0; m_phase = P_IDLE;
    end else if (model_live) begin
      ev_wr_ctrl   = bus.WE && bus.Addr[3:2] == 2'd0;
      ev_wr_preset = bus.WE && bus.Addr[3:2] == 2'd1;
`ifdef TIMER_AUTORELOAD_EN
      ev_reload = (m_mode == 2'd1);
`else
      ev_reload = 1'b0;
`endif
      irq_next   = m_flag && m_im;
      ev_expire  = 1'b0;
      next_phase = P_IDLE;
      // Timer rules: arm when enabled, load, count toward 0, expire, then either stop or re-arm
      if (m_phase == P_IDLE) next_phase = m_en ? P_LOAD : P_IDLE;
      else if (m_phase == P_LOAD) begin
        m_count = m_preset;
        next_phase = P_CNT;
      end else if (m_phase == P_CNT) begin
        if (!m_en) next_phase = P_IDLE;
        else if (m_count >= 2) begin
          m_count = m_count - 1;
          next_phase = P_CNT;
        end else begin
          m_count = 0;
          ev_expire = 1'b1;
          next_phase = P_INT;
        end
      end else begin
        if (ev_reload) m_flag = 1'b0;
        else m_en = 1'b0;
      end
      if (ev_wr_ctrl) begin
        m_en = bus.Din[0];
        m_im = bus.Din[3];
`ifdef TIMER_AUTORELOAD_EN
        m_mode = bus.Din[2:1];
`else
        m_mode = 2'd0;
`endif
        m_flag = 1'b0;
      end
      if (ev_wr_preset) m_preset = bus.Din;
      if (ev_expire) m_flag = 1'b1;
      m_irq   = irq_next;
      m_phase = next_phase;
    end
  end

  // Every-cycle comparison of all observable outputs against the model
  always @(negedge clk) begin
    if (model_live) begin
      check("dout", bus.Dout, m_read(bus.Addr[3:2]));
      check("irq", {31'd0, bus.IRQ}, {31'd0, m_irq});
      check("state", 32'(dbg_state), 32'(phase_enum(m_phase)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = {26'($urandom), a, 2'($urandom)};
    bus.WE   = 1'b1;
    bus.Din  = d;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = {26'($urandom), a, 2'($urandom)};
    #1;
    d = bus.Dout;
  endtask

  task automatic wait_state(input timer_state_e s, input int budget, input string name);
    int n = 0;
    while (dbg_state != s && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(dbg_state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  logic [31:0] wd;
  int          ones, consec, r;
  logic        prev_irq;

  initial begin
    reset    = 1'b0;
    bus.WE   = 1'b0;
    bus.Addr = '0;
    bus.Din  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], d);
      check("reset_read", d, 32'd0);
    end
    check("reset_irq", {31'd0, bus.IRQ}, 32'd0);

    // One-shot countdown from 5 with interrupt enabled
    wr(REG_PRESET, 32'd5);
    wr(REG_CTRL, 32'h9);
    peek(REG_CTRL, d);
    check("ctrl_9", d, 32'h9);
    tick();
    tick();
    for (int v = 5; v >= 1; v--) begin
      peek(REG_COUNT, d);
      check("count_seq", d, 32'(v));
      tick();
    end
    peek(REG_COUNT, d);
    check("count_zero", d, 32'd0);
    check("int_state", 32'(dbg_state), 32'(ST_INT));
    check("irq_int_cycle", {31'd0, bus.IRQ}, 32'd0);
    tick();
    check("irq_set", {31'd0, bus.IRQ}, 32'd1);
    peek(REG_CTRL, d);
    check("ctrl_en_cleared", d, 32'h8);
    repeat (3) tick();
    check("irq_held", {31'd0, bus.IRQ}, 32'd1);
    wr(REG_CTRL, 32'h8);
    tick();
    check("irq_cleared", {31'd0, bus.IRQ}, 32'd0);

    // Stop mid-count: freeze at 5
    wr(REG_PRESET, 32'd10);
    wr(REG_CTRL, 32'h9);
    for (int n = 0; n < 20; n++) begin
      peek(REG_COUNT, d);
      if (d == 32'd6) break;
      tick();
    end
    check("reach_6", d, 32'd6);
    wr(REG_CTRL, 32'h8);
    peek(REG_COUNT, d);
    check("count_5", d, 32'd5);
    tick();
    check("stop_idle", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) tick();
    peek(REG_COUNT, d);
    check("frozen_5", d, 32'd5);
    check("stop_no_irq", {31'd0, bus.IRQ}, 32'd0);

    // PRESET=0 with IM=0: expires without wrap, IRQ masked
    wr(REG_PRESET, 32'd0);
    wr(REG_CTRL, 32'h1);
    wait_state(ST_INT, 10, "p0_int");
    peek(REG_COUNT, d);
    check("p0_count", d, 32'd0);
    tick();
    check("masked_irq", {31'd0, bus.IRQ}, 32'd0);
    peek(REG_CTRL, d);
    check("p0_ctrl", d, 32'd0);
    wr(REG_CTRL, 32'h8);
    tick();
    check("unmask_irq", {31'd0, bus.IRQ}, 32'd0);
    tick();
    check("unmask_irq2", {31'd0, bus.IRQ}, 32'd0);

    // Reset mid-count
    wr(REG_PRESET, 32'd20);
    wr(REG_CTRL, 32'h9);
    repeat (8) tick();
    peek(REG_COUNT, d);
    check("precount_14", d, 32'd14);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int a = 0; a < 3; a++) begin
      peek(a[1:0], d);
      check("midreset_read", d, 32'd0);
    end
    check("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
    ones = 0;
    repeat (25) begin
      tick();
      if (bus.IRQ) ones++;
    end
    check("midreset_no_irq", 32'(ones), 32'd0);

`ifdef TIMER_AUTORELOAD_EN
    // Auto-reload: periodic one-cycle pulses every 6 cycles
    wr(REG_PRESET, 32'd3);
    wr(REG_CTRL, 32'hB);
    for (int n = 0; n < 20 && !bus.IRQ; n++) tick();
    check("ar_first_pulse", {31'd0, bus.IRQ}, 32'd1);
    ones = 0;
    consec = 0;
    prev_irq = bus.IRQ;
    for (int n = 0; n < 36; n++) begin
      tick();
      if (bus.IRQ) ones++;
      if (bus.IRQ && prev_irq) consec++;
      prev_irq = bus.IRQ;
    end
    check("ar_pulse_count", 32'(ones), 32'd6);
    check("ar_pulse_width", 32'(consec), 32'd0);
    peek(REG_CTRL, d);
    check("ar_ctrl", d, 32'hB);
    wr(REG_CTRL, 32'h0);
`endif

    // Random register traffic, checked by the every-cycle compare
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        peek(2'($urandom), d);
        tick();
      end else if (r < 74) begin
        wd = $urandom;
        wd[0] = ($urandom_range(0, 3) != 0);
        wr(REG_CTRL, wd);
      end else if (r < 86) begin
        wr(REG_PRESET, 32'($urandom_range(0, 12)));
      end else if (r < 93) begin
        wr($urandom_range(0, 1) ? REG_COUNT : REG_RSVD, $urandom);
      end else if (r < 97) begin
        wr(REG_PRESET, $urandom);
      end else begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
